// File: rtl/uiudp_tx_pkt_if.sv
// Bundle of the source byte stream and the UDP stack user-write signals
// that surround uiudp_tx_pkt. The master modport is the packetiser side;
// the slave modport is whatever feeds bytes in and plays the stack.
interface uiudp_tx_pkt_if;
    logic        I_src_valid;
    logic [7:0]  I_src_data;
    logic        I_src_last;
    logic        O_src_ready;
    logic        O_udp_req;
    logic [15:0] O_udp_len;
    logic        O_udp_valid;
    logic [7:0]  O_udp_data;
    logic        I_udp_busy;
    logic [15:0] O_frame_id;
    logic        O_pkt_sent;

    modport master (
        input  I_src_valid, I_src_data, I_src_last, I_udp_busy,
        output O_src_ready, O_udp_req, O_udp_len, O_udp_valid, O_udp_data,
               O_frame_id, O_pkt_sent
    );

    modport slave (
        output I_src_valid, I_src_data, I_src_last, I_udp_busy,
        input  O_src_ready, O_udp_req, O_udp_len, O_udp_valid, O_udp_data,
               O_frame_id, O_pkt_sent
    );
endinterface

// File: rtl/uiudp_tx_pkt.sv
// UDP user-side transmit packetiser: buffers a byte stream into packets of
// up to MAX_PAYLOAD bytes, then issues one stack write per packet with an
// optional {frame_id, pkt_seq} header in front of the payload.
module uiudp_tx_pkt #(
    parameter int MAX_PAYLOAD = 1024,
    parameter bit HDR_EN      = 1'b1,
    parameter int ADDR_W      = 10
) (
    input  logic          I_uclk,
    input  logic          I_reset,
    uiudp_tx_pkt_if.master bus
);
    // Count must reach MAX_PAYLOAD itself, which may equal 2^ADDR_W.
    localparam int                CNT_W   = ADDR_W + 1;
    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_PAYLOAD);
    localparam logic [15:0]       HDR_LEN = HDR_EN ? 16'd4 : 16'd0;

    typedef enum logic [2:0] {
        S_FILL,
        S_REQ,
        S_HDR,
        S_PAY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               last_flag_q, last_flag_d;
    logic [15:0]        frame_id_q, frame_id_d;
    logic [15:0]        pkt_seq_q, pkt_seq_d;
    logic               valid_q, valid_d;
    logic               pay_sel_q, pay_sel_d;
    logic [7:0]         hdr_byte_q, hdr_byte_d;
    logic               pkt_sent_q, pkt_sent_d;

    logic [7:0]         mem [0:DEPTH-1];
    logic [7:0]         mem_rd_q;
    logic [ADDR_W-1:0]  rd_addr;
    logic               wr_en;
    logic               src_ready;
    logic               accept;

    // Ready is a pure decode of FILL, suppressed while reset is held so no
    // byte is taken during the reset cycle.
    assign src_ready = (state_q == S_FILL) && !I_reset;
    assign accept    = bus.I_src_valid && src_ready;

    // Next-state, counters, sequence numbering and buffer addressing.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        last_flag_d = last_flag_q;
        frame_id_d  = frame_id_q;
        pkt_seq_d   = pkt_seq_q;
        pkt_sent_d  = 1'b0;
        wr_en       = 1'b0;
        rd_addr     = '0;
        valid_d     = 1'b0;
        pay_sel_d   = 1'b0;
        hdr_byte_d  = 8'h00;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if ((count_q + 1'b1 == MAX_CNT) || bus.I_src_last) begin
                        state_d     = S_REQ;
                        last_flag_d = bus.I_src_last;
                    end
                end
            end
            S_REQ: begin
                // Address 0 is presented here too so a header-less packet
                // has its first byte ready on the first payload cycle.
                if (bus.I_udp_busy) begin
                    idx_d   = '0;
                    state_d = HDR_EN ? S_HDR : S_PAY;
                end
            end
            S_HDR: begin
                // Read of buffer[0] is in flight during the last header byte.
                if (idx_q == CNT_W'(3)) begin
                    idx_d   = '0;
                    state_d = S_PAY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_PAY: begin
                // Prefetch one ahead to cover the one-cycle RAM latency.
                rd_addr = ADDR_W'(idx_q + 1'b1);
                if (idx_q == count_q - 1'b1) begin
                    state_d    = S_DONE;
                    pkt_sent_d = 1'b1;
                    count_d    = '0;
                    if (last_flag_q) begin
                        frame_id_d = frame_id_q + 16'd1;
                        pkt_seq_d  = 16'd0;
                    end else begin
                        pkt_seq_d  = pkt_seq_q + 16'd1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.I_udp_busy) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        // Output stage values for the coming cycle.
        valid_d   = (state_d == S_HDR) || (state_d == S_PAY);
        pay_sel_d = (state_d == S_PAY);
        if (state_d == S_HDR) begin
            case (idx_d[1:0])
                2'd0:    hdr_byte_d = frame_id_q[15:8];
                2'd1:    hdr_byte_d = frame_id_q[7:0];
                2'd2:    hdr_byte_d = pkt_seq_q[15:8];
                default: hdr_byte_d = pkt_seq_q[7:0];
            endcase
        end
    end

    // State, counters and registered output stage.
    always_ff @(posedge I_uclk) begin
        if (I_reset) begin
            state_q     <= S_FILL;
            count_q     <= '0;
            idx_q       <= '0;
            last_flag_q <= 1'b0;
            frame_id_q  <= 16'd0;
            pkt_seq_q   <= 16'd0;
            valid_q     <= 1'b0;
            pay_sel_q   <= 1'b0;
            hdr_byte_q  <= 8'h00;
            pkt_sent_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            last_flag_q <= last_flag_d;
            frame_id_q  <= frame_id_d;
            pkt_seq_q   <= pkt_seq_d;
            valid_q     <= valid_d;
            pay_sel_q   <= pay_sel_d;
            hdr_byte_q  <= hdr_byte_d;
            pkt_sent_q  <= pkt_sent_d;
        end
    end

    // Payload buffer: write at the fill count, registered read.
    always_ff @(posedge I_uclk) begin
        if (wr_en) begin
            mem[count_q[ADDR_W-1:0]] <= bus.I_src_data;
        end
        mem_rd_q <= mem[rd_addr];
    end

    assign bus.O_src_ready = src_ready;
    assign bus.O_udp_req   = (state_q == S_REQ);
    assign bus.O_udp_len   = (state_q == S_REQ) ? (16'(count_q) + HDR_LEN) : 16'd0;
    assign bus.O_udp_valid = valid_q;
    assign bus.O_udp_data  = pay_sel_q ? mem_rd_q : hdr_byte_q;
    assign bus.O_frame_id  = frame_id_q;
    assign bus.O_pkt_sent  = pkt_sent_q;

endmodule

// File: tb/tb_uiudp_tx_pkt.sv
// Bench for uiudp_tx_pkt: one instance with header (MAX_PAYLOAD=8) and one
// without, selected by sel; expected streams come from a packet-level model.
module tb_uiudp_tx_pkt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_last = 1'b0;
    logic       busy = 1'b0;

    uiudp_tx_pkt_if ifa ();
    uiudp_tx_pkt_if ifb ();

    assign ifa.I_src_valid = !sel && src_valid;
    assign ifa.I_src_data  = src_data;
    assign ifa.I_src_last  = !sel && src_last;
    assign ifa.I_udp_busy  = !sel && busy;
    assign ifb.I_src_valid = sel && src_valid;
    assign ifb.I_src_data  = src_data;
    assign ifb.I_src_last  = sel && src_last;
    assign ifb.I_udp_busy  = sel && busy;

    uiudp_tx_pkt #(.MAX_PAYLOAD(8), .HDR_EN(1'b1), .ADDR_W(3)) dut_a (
        .I_uclk(clk), .I_reset(rst), .bus(ifa));
    uiudp_tx_pkt #(.MAX_PAYLOAD(8), .HDR_EN(1'b0), .ADDR_W(3)) dut_b (
        .I_uclk(clk), .I_reset(rst), .bus(ifb));

    wire        rdy_m = sel ? ifb.O_src_ready : ifa.O_src_ready;
    wire        req_m = sel ? ifb.O_udp_req   : ifa.O_udp_req;
    wire [15:0] len_m = sel ? ifb.O_udp_len   : ifa.O_udp_len;
    wire        vld_m = sel ? ifb.O_udp_valid : ifa.O_udp_valid;
    wire [7:0]  dat_m = sel ? ifb.O_udp_data  : ifa.O_udp_data;
    wire [15:0] fid_m = sel ? ifb.O_frame_id  : ifa.O_frame_id;
    wire        pls_m = sel ? ifb.O_pkt_sent  : ifa.O_pkt_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    logic [7:0] cap_q[$];
    int         cap_cyc[$];

    logic [7:0]  pay [8];
    logic [15:0] frame_m [2];
    logic [15:0] seq_m [2];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every byte the selected instance puts on the stack port.
    always @(negedge clk) begin
        if (vld_m === 1'b1) begin
            cap_q.push_back(dat_m);
            cap_cyc.push_back(cyc);
        end
        if (pls_m === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bytes(input int n, input bit last_end);
        bit acc;
        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_data  = pay[i];
            src_last  = last_end && (i == n - 1);
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                if (rdy_m === 1'b1) acc = 1'b1;
                @(posedge clk); #1;
            end
            check("src_accept", 32'(acc), 1);
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
    endtask

    // One complete packet: fill, request, transfer, done; compare with model.
    task automatic run_pkt(input int n, input bit last_end, input int busy_delay, input int done_hold);
        int s, hd, base, pbase, rc;
        logic [15:0] exp_len, f, q;
        logic [7:0]  exp_q[$];
        bit req_ok, len_ok, quiet_ok, rdy_ok, got;
        s  = sel ? 1 : 0;
        hd = sel ? 0 : 4;
        exp_len = 16'(n + hd);
        f = frame_m[s];
        q = seq_m[s];
        exp_q = {};
        if (hd != 0) begin
            exp_q.push_back(f[15:8]); exp_q.push_back(f[7:0]);
            exp_q.push_back(q[15:8]); exp_q.push_back(q[7:0]);
        end
        for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
        base  = cap_q.size();
        pbase = pulse_cnt;

        send_bytes(n, last_end);
        check("req_asserted", 32'(req_m), 1);
        check("udp_len", 32'(len_m), 32'(exp_len));
        req_ok = 1; len_ok = 1; quiet_ok = 1; rdy_ok = 1;
        for (int k = 0; k < busy_delay; k++) begin
            if (req_m !== 1'b1) req_ok = 0;
            if (len_m !== exp_len) len_ok = 0;
            if (vld_m !== 1'b0 || rdy_m !== 1'b0) quiet_ok = 0;
            @(posedge clk); #1;
        end
        busy = 1'b1;
        rc = cyc;
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(posedge clk); #1;
            if (rdy_m !== 1'b0) rdy_ok = 0;
            if (pls_m === 1'b1) got = 1;
        end
        check("pkt_sent_seen", 32'(got), 1);
        for (int k = 0; k < done_hold; k++) begin
            @(posedge clk); #1;
            if (rdy_m !== 1'b0) rdy_ok = 0;
        end
        busy = 1'b0;
        @(posedge clk); #1;
        check("ready_back", 32'(rdy_m), 1);
        check("req_held", 32'(req_ok), 1);
        check("len_stable", 32'(len_ok), 1);
        check("quiet_in_req", 32'(quiet_ok), 1);
        check("ready_low", 32'(rdy_ok), 1);
        check("pulse_count", 32'(pulse_cnt - pbase), 1);
        check("valid_cycles", 32'(cap_q.size() - base), 32'(exp_len));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < cap_q.size())
                check($sformatf("byte%0d", i), 32'(cap_q[base + i]), 32'(exp_q[i]));
        if (cap_q.size() > base) begin
            check("contiguous", 32'(cap_cyc[cap_q.size() - 1] - cap_cyc[base] + 1), 32'(exp_len));
            check("start_latency", 32'(cap_cyc[base] - rc <= 2), 1);
        end
        if (last_end) begin
            frame_m[s] = frame_m[s] + 16'd1;
            seq_m[s]   = 16'd0;
        end else begin
            seq_m[s] = seq_m[s] + 16'd1;
        end
        check("frame_id", 32'(fid_m), 32'(frame_m[s]));
        $display("pkt sel=%0d n=%0d last=%0d len=%0d frame=%0d seq=%0d", sel, n, last_end, exp_len, f, q);
    endtask

    initial begin
        int n, base;
        bit l, got;
        frame_m = '{16'd0, 16'd0};
        seq_m   = '{16'd0, 16'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy_m), 0);
        check("rst_req", 32'(req_m), 0);
        check("rst_valid", 32'(vld_m), 0);
        check("rst_len", 32'(len_m), 0);
        check("rst_frame", 32'(fid_m), 0);
        check("rst_sent", 32'(pls_m), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(rdy_m), 1);

        // Full packet 0x10..0x17 with no last, busy three cycles after req
        for (int i = 0; i < 8; i++) pay[i] = 8'(8'h10 + i);
        run_pkt(8, 1'b0, 3, 0);

        // Short frame end: 3 bytes, last on the third
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_pkt(3, 1'b1, 1, 1);

        // Long busy=0 wait in REQ, then long busy=1 hold in DONE
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_pkt(5, 1'b1, 50, 20);

        // Last flag on the byte that also fills the buffer: no empty packet follows
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_pkt(8, 1'b1, 0, 0);
        got = 0;
        for (int k = 0; k < 5; k++) begin
            if (req_m !== 1'b0) got = 1;
            @(posedge clk); #1;
        end
        check("no_empty_pkt", 32'(got), 0);

        // Random packets
        for (int p = 0; p < 6; p++) begin
            n = int'($urandom_range(1, 8));
            l = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
            run_pkt(n, l, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        end

        // Reset in the middle of the payload
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        base = cap_q.size();
        send_bytes(6, 1'b1);
        busy = 1'b1;
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(posedge clk); #1;
            if (cap_q.size() - base >= 8) got = 1;
        end
        check("reached_pay_byte4", 32'(got), 1);
        rst = 1'b1;
        busy = 1'b0;
        @(posedge clk); #1;
        check("valid_after_rst", 32'(vld_m), 0);
        check("req_after_rst", 32'(req_m), 0);
        check("frame_after_rst", 32'(fid_m), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_mid_rst", 32'(rdy_m), 1);
        $display("reset during payload");
        frame_m = '{16'd0, 16'd0};
        seq_m   = '{16'd0, 16'd0};
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_pkt(4, 1'b1, 2, 1);

        // Header-less instance: 5 bytes with last
        sel = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_pkt(5, 1'b1, 2, 1);
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_pkt(8, 1'b0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
